// File: rtl/iomem_gpio.sv
// iomem_gpio: GPIO peripheral for the PicoSoC iomem bus.
// Provides per-bit output data and output enable, a synchronised input path,
// atomic set/clear of the output register and, when the macro
// IOMEM_GPIO_IRQ_EN is defined, per-bit edge-triggered interrupts that are
// combined into one registered level interrupt.
// Reset is synchronous and active-low (resetn).

module iomem_gpio #(
  parameter int         WIDTH       = 32,
  parameter logic [7:0] BASE_ADDR   = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  // Word offsets, iomem_addr[4:2].
  localparam logic [2:0] OFF_OUT  = 3'd0;
  localparam logic [2:0] OFF_DIR  = 3'd1;
  localparam logic [2:0] OFF_IN   = 3'd2;
  localparam logic [2:0] OFF_SET  = 3'd3;
  localparam logic [2:0] OFF_CLR  = 3'd4;
  localparam logic [2:0] OFF_EN   = 3'd5;
  localparam logic [2:0] OFF_EDGE = 3'd6;
  localparam logic [2:0] OFF_PEND = 3'd7;

  // Handshake: a request is taken when iomem_valid is high, the address is in
  // our window and no response is being presented (ready_q low). The access
  // completes with a single-cycle ready_q pulse one cycle later; rdata_q holds
  // the pre-write register value alongside it. Unselected requests are left
  // alone so another slave may answer them.
  logic             ready_q;
  logic [31:0]      rdata_q;
  logic             sel;
  logic             wr;
  logic [2:0]       offset;
  logic [31:0]      wmask;
  logic [31:0]      wbits;
  logic [31:0]      rd_val;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_s;

  logic [31:0]      en_rd;
  logic [31:0]      edge_rd;
  logic [31:0]      pend_rd;

  logic             unused_addr;

  assign sel    = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
  assign wr     = sel && (iomem_wstrb != 4'b0000);
  assign offset = iomem_addr[4:2];
  assign wmask  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                   {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wbits  = iomem_wdata & wmask;

  // Address bits that only alias through the window.
  assign unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0]};

  // Byte-strobed replace of a register; bits at or above WIDTH drop out.
  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [31:0]      wd,
                                             input logic [31:0]      m);
    logic [31:0] r;
    r = (32'(old) & ~m) | (wd & m);
    return r[WIDTH-1:0];
  endfunction

  // Pad synchroniser: SYNC_STAGES flops, last stage is the sampled input.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign in_s = sync_q[SYNC_STAGES-1];

  // Next value of OUT and DIR from the current bus write, if any.
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr) begin
      case (offset)
        OFF_OUT: out_d = merge(out_q, iomem_wdata, wmask);
        OFF_DIR: dir_d = merge(dir_q, iomem_wdata, wmask);
        OFF_SET: out_d = out_q | wbits[WIDTH-1:0];
        OFF_CLR: out_d = out_q & ~wbits[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Output data and output enable registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_q <= '0;
      dir_q <= '0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
    end
  end

`ifdef IOMEM_GPIO_IRQ_EN
  logic [WIDTH-1:0] in_p_q;
  logic [WIDTH-1:0] en_q, en_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt;
  logic             irq_q;

  assign rise = in_s & ~in_p_q;
  assign fall = ~in_s & in_p_q;
  assign evt  = (edge_q & rise) | (~edge_q & fall);

  // IRQ register updates; a fresh event beats a same-cycle W1C.
  always_comb begin
    en_d   = en_q;
    edge_d = edge_q;
    pend_d = pend_q;
    if (wr) begin
      case (offset)
        OFF_EN:   en_d   = merge(en_q, iomem_wdata, wmask);
        OFF_EDGE: edge_d = merge(edge_q, iomem_wdata, wmask);
        OFF_PEND: pend_d = pend_q & ~wbits[WIDTH-1:0];
        default:  ;
      endcase
    end
    pend_d = pend_d | evt;
  end

  // Edge-detect history, IRQ registers and the registered interrupt level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      in_p_q <= '0;
      en_q   <= '0;
      edge_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      in_p_q <= in_s;
      en_q   <= en_d;
      edge_q <= edge_d;
      pend_q <= pend_d;
      irq_q  <= |(pend_q & en_q);
    end
  end

  assign irq     = irq_q;
  assign en_rd   = 32'(en_q);
  assign edge_rd = 32'(edge_q);
  assign pend_rd = 32'(pend_q);
`else
  assign irq     = 1'b0;
  assign en_rd   = 32'h0;
  assign edge_rd = 32'h0;
  assign pend_rd = 32'h0;
`endif

  // Read mux: current (pre-write) register contents.
  always_comb begin
    rd_val = 32'h0;
    case (offset)
      OFF_OUT:  rd_val = 32'(out_q);
      OFF_DIR:  rd_val = 32'(dir_q);
      OFF_IN:   rd_val = 32'(in_s);
      OFF_SET:  rd_val = 32'(out_q);
      OFF_CLR:  rd_val = 32'(out_q);
      OFF_EN:   rd_val = en_rd;
      OFF_EDGE: rd_val = edge_rd;
      OFF_PEND: rd_val = pend_rd;
      default:  rd_val = 32'h0;
    endcase
  end

  // Bus response: one-cycle ready pulse with the read data captured with it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ready_q <= sel;
      if (sel) rdata_q <= rd_val;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_out    = out_q;
  assign gpio_oe     = dir_q;

endmodule

// File: tb/tb_iomem_gpio.sv
// Testbench for iomem_gpio: a 32-bit instance checked every cycle against a
// register-level model, plus an 8-bit instance for width masking.
// Build with or without IOMEM_GPIO_IRQ_EN; expectations follow the macro.

module tb_iomem_gpio;

  localparam int S = 2;
`ifdef IOMEM_GPIO_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  localparam logic [31:0] A_OUT  = 32'h0300_0000;
  localparam logic [31:0] A_DIR  = 32'h0300_0004;
  localparam logic [31:0] A_IN   = 32'h0300_0008;
  localparam logic [31:0] A_SET  = 32'h0300_000C;
  localparam logic [31:0] A_CLR  = 32'h0300_0010;
  localparam logic [31:0] A_EN   = 32'h0300_0014;
  localparam logic [31:0] A_EDGE = 32'h0300_0018;
  localparam logic [31:0] A_PEND = 32'h0300_001C;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  always #5 clk = ~clk;

  logic        valid = 1'b0;
  logic        valid8 = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] gpio_in = 32'h0;
  logic [7:0]  gpio_in8 = 8'h0;

  logic        ready, ready8;
  logic [31:0] rdata, rdata8;
  logic [31:0] gpio_out, gpio_oe;
  logic [7:0]  out8, oe8;
  logic        irq, irq8;

  iomem_gpio #(.WIDTH(32), .BASE_ADDR(8'h03), .SYNC_STAGES(S)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_ready(ready),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata),
    .iomem_rdata(rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  iomem_gpio #(.WIDTH(8), .BASE_ADDR(8'h03), .SYNC_STAGES(S)) dut8 (
    .clk(clk), .resetn(resetn), .iomem_valid(valid8), .iomem_ready(ready8),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata),
    .iomem_rdata(rdata8), .gpio_in(gpio_in8), .gpio_out(out8),
    .gpio_oe(oe8), .irq(irq8)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- register-level model of the 32-bit instance ----------------
  logic [31:0] m_out = 0, m_dir = 0, m_en = 0, m_edge = 0, m_pend = 0, m_rdata = 0;
  logic        m_ready = 0, m_irq = 0;
  logic [31:0] hist[$];   // pad samples, index 0 = newest

  initial for (int i = 0; i <= S; i++) hist.push_back(32'h0);

  always @(posedge clk) begin
    logic [31:0] in_s, in_p, evt, wm, wb, rd, pend_w;
    logic        rdy, irq_n;
    in_s = hist[S-1];
    in_p = hist[S];
    if (!resetn) begin
      m_out = 0; m_dir = 0; m_en = 0; m_edge = 0; m_pend = 0;
      m_rdata = 0; m_ready = 0; m_irq = 0;
      for (int i = 0; i <= S; i++) hist[i] = 32'h0;
    end else begin
      evt    = HAS_IRQ ? ((m_edge & in_s & ~in_p) | (~m_edge & ~in_s & in_p)) : 32'h0;
      irq_n  = |(m_pend & m_en);
      pend_w = m_pend;
      rdy    = 1'b0;
      rd     = 32'h0;
      wm     = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
      wb     = wdata & wm;
      if (!m_ready && valid && addr[31:24] == 8'h03) begin
        rdy = 1'b1;
        case (addr[4:2])
          3'd0, 3'd3, 3'd4: rd = m_out;
          3'd1: rd = m_dir;
          3'd2: rd = in_s;
          3'd5: rd = m_en;
          3'd6: rd = m_edge;
          default: rd = m_pend;
        endcase
        if (wstrb != 0) begin
          case (addr[4:2])
            3'd0: m_out = (m_out & ~wm) | wb;
            3'd1: m_dir = (m_dir & ~wm) | wb;
            3'd3: m_out = m_out | wb;
            3'd4: m_out = m_out & ~wb;
            3'd5: if (HAS_IRQ) m_en = (m_en & ~wm) | wb;
            3'd6: if (HAS_IRQ) m_edge = (m_edge & ~wm) | wb;
            3'd7: pend_w = m_pend & ~wb;
            default: ;
          endcase
        end
      end
      m_pend  = pend_w | evt;
      m_irq   = irq_n;
      m_ready = rdy;
      if (rdy) m_rdata = rd;
      hist.push_front(gpio_in);
      void'(hist.pop_back());
    end
  end

  // Every-cycle comparison of the 32-bit instance against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("ready", {31'b0, ready}, {31'b0, m_ready});
      chk("gpio_out", gpio_out, m_out);
      chk("gpio_oe", gpio_oe, m_dir);
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
      if (m_ready) chk("rdata", rdata, m_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one request; reports how many cycles until ready (-1 = none in 4).
  task automatic bus(input bit use8, input logic [31:0] a, input logic [3:0] ws,
                     input logic [31:0] wd, output logic [31:0] rd, output int lat);
    @(negedge clk);
    addr = a; wstrb = ws; wdata = wd;
    if (use8) valid8 = 1'b1; else valid = 1'b1;
    rd = 32'h0;
    lat = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ((use8 ? ready8 : ready) === 1'b1) begin
        rd = use8 ? rdata8 : rdata;
        lat = i;
        break;
      end
    end
    valid = 1'b0; valid8 = 1'b0; wstrb = 4'h0;
  endtask

  task automatic rd_reg(input string name, input bit use8, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    bus(use8, a, 4'h0, 32'h0, rd, lat);
    chk({name, "_latency"}, 32'(lat), 32'd0);
    chk(name, rd, exp);
  endtask

  task automatic wr_reg(input string name, input bit use8, input logic [31:0] a,
                        input logic [3:0] ws, input logic [31:0] wd);
    logic [31:0] rd;
    int lat;
    bus(use8, a, ws, wd, rd, lat);
    chk({name, "_latency"}, 32'(lat), 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    int lat;
    logic [31:0] irq_exp;
    irq_exp = HAS_IRQ ? 32'd1 : 32'd0;

    wait_cycles(3);
    check_en = 1'b1;
    @(negedge clk);
    resetn = 1'b1;

    // Reset state across every offset.
    rd_reg("rst_out",  0, A_OUT,  32'h0);
    rd_reg("rst_dir",  0, A_DIR,  32'h0);
    rd_reg("rst_in",   0, A_IN,   32'h0);
    rd_reg("rst_set",  0, A_SET,  32'h0);
    rd_reg("rst_clr",  0, A_CLR,  32'h0);
    rd_reg("rst_en",   0, A_EN,   32'h0);
    rd_reg("rst_edge", 0, A_EDGE, 32'h0);
    rd_reg("rst_pend", 0, A_PEND, 32'h0);

    // Strobed write, set, clear (last read goes through an alias address).
    wr_reg("w_out", 0, A_OUT, 4'b0010, 32'hA5A5_5A5A);
    rd_reg("out_strb", 0, A_OUT, 32'h0000_5A00);
    wr_reg("w_set", 0, A_SET, 4'hF, 32'h0000_000F);
    rd_reg("out_set", 0, A_OUT, 32'h0000_5A0F);
    rd_reg("set_rdback", 0, A_SET, 32'h0000_5A0F);
    wr_reg("w_clr", 0, A_CLR, 4'hF, 32'h0000_0A00);
    rd_reg("out_clr_alias", 0, 32'h0312_3460, 32'h0000_500F);

    // DIR and an unselected access.
    wr_reg("w_dir", 0, A_DIR, 4'hF, 32'hFFFF_0000);
    chk("gpio_oe_lit", gpio_oe, 32'hFFFF_0000);
    bus(0, 32'h0400_0004, 4'hF, 32'h0000_1234, rd, lat);
    chk("unsel_no_ready", 32'(lat), 32'hFFFF_FFFF);
    rd_reg("dir_kept", 0, A_DIR, 32'hFFFF_0000);

    // IN is read-only and follows the pads after the synchroniser.
    wr_reg("w_in", 0, A_IN, 4'hF, 32'hFFFF_FFFF);
    rd_reg("in_ro", 0, A_IN, 32'h0);
    @(negedge clk);
    gpio_in = 32'h1234_5678;
    wait_cycles(S + 1);
    rd_reg("in_sync", 0, A_IN, 32'h1234_5678);

    // Falling edges (default edge select) latch into PEND even with IRQ_EN=0.
    @(negedge clk);
    gpio_in = 32'h0;
    wait_cycles(S + 3);
    rd_reg("pend_fall", 0, A_PEND, HAS_IRQ ? 32'h1234_5678 : 32'h0);
    wr_reg("w1c_byte", 0, A_PEND, 4'b0001, 32'hFFFF_FFFF);
    rd_reg("pend_w1c_byte", 0, A_PEND, HAS_IRQ ? 32'h1234_5600 : 32'h0);
    wr_reg("w1c_all", 0, A_PEND, 4'hF, 32'hFFFF_FFFF);
    rd_reg("pend_clear", 0, A_PEND, 32'h0);

    // Reset in the middle of a write: no ready, write discarded.
    @(negedge clk);
    addr = A_OUT; wstrb = 4'hF; wdata = 32'hFFFF_FFFF; valid = 1'b1; resetn = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", {31'b0, ready}, 32'h0);
    chk("rstmid_out", gpio_out, 32'h0);
    valid = 1'b0; wstrb = 4'h0; resetn = 1'b1;
    rd_reg("rstmid_out_rd", 0, A_OUT, 32'h0);
    rd_reg("rstmid_dir_rd", 0, A_DIR, 32'h0);

    // Width masking on the 8-bit instance.
    wr_reg("w8_out", 1, A_OUT, 4'hF, 32'hFFFF_FFFF);
    rd_reg("w8_out_rd", 1, A_OUT, 32'h0000_00FF);
    chk("w8_gpio_out", {24'h0, out8}, 32'h0000_00FF);

    // Rising-edge interrupt on bit 3.
    wr_reg("w_en", 0, A_EN, 4'hF, 32'h0000_0008);
    wr_reg("w_edge", 0, A_EDGE, 4'hF, 32'h0000_0008);
    rd_reg("en_rd", 0, A_EN, HAS_IRQ ? 32'h8 : 32'h0);
    rd_reg("edge_rd", 0, A_EDGE, HAS_IRQ ? 32'h8 : 32'h0);
    @(negedge clk);
    gpio_in = 32'h0000_0008;
    wait_cycles(S + 1);
    chk("irq_before", {31'b0, irq}, 32'h0);
    wait_cycles(1);
    chk("irq_at_s2", {31'b0, irq}, irq_exp);
    rd_reg("pend_rise", 0, A_PEND, HAS_IRQ ? 32'h8 : 32'h0);

    // Falling edge with rising select: no event, flag remains from before.
    @(negedge clk);
    gpio_in = 32'h0;
    wait_cycles(S + 3);
    rd_reg("pend_after_fall", 0, A_PEND, HAS_IRQ ? 32'h8 : 32'h0);

    // W1C landing in the same cycle as a new rising event: set wins.
    @(negedge clk);
    gpio_in = 32'h0000_0008;
    wait_cycles(S - 1);
    wr_reg("w1c_coincide", 0, A_PEND, 4'hF, 32'h0000_0008);
    wait_cycles(S + 2);
    rd_reg("pend_set_wins", 0, A_PEND, HAS_IRQ ? 32'h8 : 32'h0);
    chk("irq_still", {31'b0, irq}, irq_exp);

    // Clear the flag, then lower the pad: nothing new appears.
    wr_reg("w1c_last", 0, A_PEND, 4'hF, 32'h0000_0008);
    rd_reg("pend_cleared", 0, A_PEND, 32'h0);
    @(negedge clk);
    gpio_in = 32'h0;
    wait_cycles(S + 3);
    rd_reg("pend_no_event", 0, A_PEND, 32'h0);
    chk("irq_low", {31'b0, irq}, 32'h0);

    wait_cycles(2);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against a stalled sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/iomem_gpio.md
# iomem_gpio

Parametrised GPIO peripheral for the PicoSoC iomem bus, replacing the inline single-register GPIO in the top level. Provides up to 32 bidirectional channels with:
- per-bit output enable;
- a synchronised input path;
- atomic set/clear of outputs;
- optional edge-triggered interrupt, fed to one of the SoC's `irq_5..7` inputs.

The block sits on the iomem bus alongside other slaves and responds only inside its 16 MB address window.

## Interface

Parameters:
- `WIDTH`, 32: number of GPIO channels, 1..32.
- `BASE_ADDR`, 8'h03: value of `iomem_addr[31:24]` that selects this block.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..3.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: synchronous, active-low reset.
- `iomem_valid` in 1: bus request.
- `iomem_ready` out 1: one-cycle completion pulse.
- `iomem_wstrb` in 4: byte write strobes; 0 = read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready`=1.
- `gpio_in` in WIDTH: asynchronous pad inputs.
- `gpio_out` out WIDTH: output data to pad buffers.
- `gpio_oe` out WIDTH: per-bit output enable, 1 = drive.
- `irq` out 1: level interrupt, registered.

## Operation

Address decode and handshake:
- Selected when `iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_ADDR`.
- Register offset is `iomem_addr[4:2]`. Bits [23:5] and [1:0] are ignored; the register map aliases through the window.
- Unselected requests get no response. `iomem_ready` stays 0 so another slave can answer.

Register map (word offsets). Bits at or above WIDTH read 0 and ignore writes. Every write honours `iomem_wstrb` per byte.
- 0x00 OUT, RW: `gpio_out`.
- 0x04 DIR, RW: `gpio_oe`.
- 0x08 IN, RO: synchronised input. Writes are ignored.
- 0x0C OUT_SET, WO: each 1 bit sets OUT. Reads return OUT.
- 0x10 OUT_CLR, WO: each 1 bit clears OUT. Reads return OUT.
- 0x14 IRQ_EN, RW: per-bit interrupt enable.
- 0x18 IRQ_EDGE, RW: per-bit edge select, 1 = rising, 0 = falling.
- 0x1C IRQ_PEND, R/W1C: pending flags; writing 1 clears the flag.

Read and write semantics:
- A read returns the register value as it was before any same-access write, as in a read-modify cycle.
- Input path: a SYNC_STAGES flop chain feeds `in_s`. One more flop holds `in_p`.
- `rise = in_s & ~in_p`; `fall = ~in_s & in_p`.
- `event = IRQ_EDGE ? rise : fall`, evaluated per bit.
- `PEND |= event` every cycle, regardless of IRQ_EN.
- `irq <= |(PEND & IRQ_EN)`, registered.

Boundary conditions:
- A W1C write and a new event on the same bit in the same cycle leave the bit set; set wins.
- OUT_SET and OUT_CLR with overlapping bits cannot coincide, because the bus is single-access.
- Changing IRQ_EDGE does not retroactively set or clear PEND.
- Reset values are all 0: `iomem_ready`, `iomem_rdata`, `gpio_out`, `gpio_oe`, `irq`, the synchroniser flops, `in_p`, and all registers.
- A pad held high through reset therefore produces one rising event SYNC_STAGES+1 cycles after `resetn` deasserts.
- Reset asserted mid-transaction forces `iomem_ready`=0 in the next cycle and discards the write.

## Timing

- Request sampled at edge N; `iomem_ready`=1 and `iomem_rdata` valid during cycle N+1, for exactly one cycle.
- `iomem_ready` drops at N+2 even if `iomem_valid` is still high. The master must deassert `iomem_valid` after the ready pulse.
- Back-to-back accesses complete at most every 2 cycles.
- Write effect is visible on `gpio_out`/`gpio_oe` in cycle N+1, together with `iomem_ready`.
- Pad change to IN readback latency: SYNC_STAGES cycles.
- Pad edge to PEND set: SYNC_STAGES+1 cycles.
- Pad edge to `irq`: SYNC_STAGES+2 cycles.
- W1C of the last enabled pending bit at edge N: `irq` drops at N+2.

## Configuration

Macro `IOMEM_GPIO_IRQ_EN`:
- **Defined:** edge detection, IRQ_EN, IRQ_EDGE, IRQ_PEND and `irq` are implemented as described above.
- **Undefined:**
  - `in_p`, the edge logic and the three IRQ registers are not synthesised.
  - Offsets 0x14–0x1C read 0 and ignore writes, but still complete with `iomem_ready`.
  - `irq` is tied to 0.
  - The input synchroniser and IN register remain.

## Test plan

- **Reset then read all offsets:** every read returns 0, and `iomem_ready` pulses exactly once per access, 1 cycle after valid.
- **Strobed write and set/clear, WIDTH=32:**
  - Write OUT=0xA5A5_5A5A with `wstrb`=4'b0010: OUT reads 0x0000_5A00.
  - OUT_SET 0x0000_000F: OUT reads 0x0000_5A0F.
  - OUT_CLR 0x0000_0A00: OUT reads 0x0000_500F.
- **DIR and unselected address:** write DIR=0xFFFF_0000 and confirm `gpio_oe` matches. Then access at `addr`=0x0400_0004: no `iomem_ready` within 4 cycles, and DIR is unchanged.
- **WIDTH=8 masking:** write OUT=0xFFFF_FFFF; OUT reads 0x0000_00FF and `gpio_out`=8'hFF.
- **Edge IRQ, macro defined:**
  - Set IRQ_EN[3]=1 and IRQ_EDGE[3]=1, then raise `gpio_in[3]`.
  - `irq`=1 exactly SYNC_STAGES+2 cycles later, and PEND reads 0x8.
  - W1C 0x8 coincident with a second rise on bit 3: PEND stays 0x8.
  - Lower bit 3: no new event.
- **Macro undefined:** repeat the previous stimulus. `irq` stays 0 and offset 0x1C reads 0.
